// File: rtl/rv_pkg.sv
// Shared RV core definitions: default datapath width, register index type, ALU opcode encoding
// and a helper that masks register indices beyond the implemented register count.
package rv_pkg;

  localparam int unsigned XLEN_DEFAULT = 16;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSll  = 4'b0001,
    AluSlt  = 4'b0010,
    AluSltu = 4'b0011,
    AluXor  = 4'b0100,
    AluSrl  = 4'b0101,
    AluOr   = 4'b0110,
    AluAnd  = 4'b0111,
    AluSub  = 4'b1000,
    AluSra  = 4'b1101
  } alu_op_t;

  // Bit i set when register index i exists for a file of nreg entries.
  function automatic logic [31:0] reg_mask(input int unsigned nreg);
    return (nreg >= 32) ? '1 : 32'((64'd1 << nreg) - 64'd1);
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file with two asynchronous read ports and one synchronous write port; x0 reads as
// zero and ignores writes. Synchronous active-low reset clears every entry.
module regfile_2r1w
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  localparam logic [31:0] RegMask = reg_mask(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0) && RegMask[waddr]) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata1 = ((raddr1 != '0) && RegMask[raddr1]) ? regs_q[raddr1] : '0;
    rdata2 = ((raddr2 != '0) && RegMask[raddr2]) ? regs_q[raddr2] : '0;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboarded register read with a one-entry output register toward the ALU.
// Define OPFETCH_BYPASS_EN to forward a same-cycle writeback to source operands.
module operand_fetch
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [4:0]      in_rd_addr,
  input  logic [3:0]      in_alu_op,
  input  logic            in_use_imm,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  output logic [3:0]      out_alu_op,
  output logic [4:0]      out_rd_addr,
  input  logic            wb_valid,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush
);

  localparam logic [31:0] RegMask = reg_mask(NREG);

  logic [NREG-1:0] busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_rs1_q, out_rs1_d;
  logic [XLEN-1:0] out_rs2_q, out_rs2_d;
  logic [3:0]      out_alu_op_q, out_alu_op_d;
  reg_addr_t       out_rd_addr_q, out_rd_addr_d;

  logic [XLEN-1:0] rf_rdata1, rf_rdata2, rs1_val, rs2_val;
  logic            fwd_rs1, fwd_rs2, haz_rs1, haz_rs2, haz_rd, hazard, accept;

  regfile_2r1w #(
    .XLEN(XLEN),
    .NREG(NREG)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr1(in_rs1_addr),
    .rdata1(rf_rdata1),
    .raddr2(in_rs2_addr),
    .rdata2(rf_rdata2),
    .we    (wb_valid),
    .waddr (wb_addr),
    .wdata (wb_data)
  );

  function automatic logic is_busy(input logic [NREG-1:0] busy, input reg_addr_t addr);
    return RegMask[addr] && busy[addr];
  endfunction

`ifdef OPFETCH_BYPASS_EN
  assign fwd_rs1 = wb_valid && (wb_addr == in_rs1_addr) && (in_rs1_addr != '0);
  assign fwd_rs2 = wb_valid && (wb_addr == in_rs2_addr) && (in_rs2_addr != '0);
`else
  assign fwd_rs1 = 1'b0;
  assign fwd_rs2 = 1'b0;
`endif

  always_comb begin
    haz_rs1  = is_busy(busy_q, in_rs1_addr) && !fwd_rs1;
    haz_rs2  = !in_use_imm && is_busy(busy_q, in_rs2_addr) && !fwd_rs2;
    haz_rd   = is_busy(busy_q, in_rd_addr);
    hazard   = haz_rs1 || haz_rs2 || haz_rd;
    in_ready = !hazard && (!out_valid_q || out_ready) && !flush;
    accept   = in_valid && in_ready;
    rs1_val  = fwd_rs1 ? wb_data : rf_rdata1;
    rs2_val  = in_use_imm ? in_imm : (fwd_rs2 ? wb_data : rf_rdata2);
  end

  // Clear before set so an accept that targets the register being written back keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wb_valid && RegMask[wb_addr]) begin
        busy_d[wb_addr] = 1'b0;
      end
      if (accept && (in_rd_addr != '0) && RegMask[in_rd_addr]) begin
        busy_d[in_rd_addr] = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_rs1_d     = out_rs1_q;
    out_rs2_d     = out_rs2_q;
    out_alu_op_d  = out_alu_op_q;
    out_rd_addr_d = out_rd_addr_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      out_rs1_d     = rs1_val;
      out_rs2_d     = rs2_val;
      out_alu_op_d  = in_alu_op;
      out_rd_addr_d = in_rd_addr;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q        <= '0;
      out_valid_q   <= 1'b0;
      out_rs1_q     <= '0;
      out_rs2_q     <= '0;
      out_alu_op_q  <= '0;
      out_rd_addr_q <= '0;
    end else begin
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
      out_rs1_q     <= out_rs1_d;
      out_rs2_q     <= out_rs2_d;
      out_alu_op_q  <= out_alu_op_d;
      out_rd_addr_q <= out_rd_addr_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_rs1     = out_rs1_q;
  assign out_rs2     = out_rs2_q;
  assign out_alu_op  = out_alu_op_q;
  assign out_rd_addr = out_rd_addr_q;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 16, operand/data width.
REQ-002 SHALL have parameter NREG, default 32, architectural register count.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the decoded-instruction handshake.
REQ-006 SHALL have port in_rs1_addr, input, 5, source register 1 index.
REQ-007 SHALL have port in_rs2_addr, input, 5, source register 2 index.
REQ-008 SHALL have port in_rd_addr, input, 5, destination register index.
REQ-009 SHALL have ports in_alu_op (input, 4, ALU opcode) and in_use_imm (input, 1, select immediate for operand 2).
REQ-010 SHALL have port in_imm, input, XLEN, sign-extended immediate.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the ALU-side handshake.
REQ-012 SHALL have ports out_rs1 and out_rs2 (output, XLEN, ALU operands).
REQ-013 SHALL have ports out_alu_op (output, 4) and out_rd_addr (output, 5).
REQ-014 SHALL have ports wb_valid (input, 1), wb_addr (input, 5) and wb_data (input, XLEN), the writeback port.
REQ-015 SHALL have port flush, input, 1, discard the held instruction and clear the scoreboard.

Function
REQ-016 SHALL hold NREG x XLEN registers; x0 reads 0; writes to x0 are ignored.
REQ-017 SHALL write wb_data to wb_addr at the clock edge when wb_valid=1.
REQ-018 SHALL keep busy[NREG-1:0]; set busy[rd] when an instruction with rd!=0 is accepted; clear busy[wb_addr] when wb_valid=1.
REQ-019 SHALL give set priority when set and clear hit the same register in the same cycle.
REQ-020 SHALL stall (in_ready=0) while busy[rs1], busy[rs2] (only when in_use_imm=0) or busy[rd] (WAW) is set.
REQ-021 SHALL drive in_ready = !hazard && (!out_valid || out_ready) && !flush.
REQ-022 SHALL accept an instruction when in_valid && in_ready, registering operands, opcode and rd; out_valid rises the next cycle (latency 1).
REQ-023 SHALL drive out_rs2 = in_imm when in_use_imm=1, otherwise the register value.
REQ-024 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-025 SHALL clear out_valid on out_valid && out_ready unless a new instruction is accepted in the same cycle.
REQ-026 SHALL, on flush=1, clear out_valid and all busy bits at the next edge; a wb write in the same cycle still updates the register file.

Reset
REQ-027 SHALL, at a clock edge with rst_n=0, clear all registers, all busy bits, out_valid, out_rs1, out_rs2, out_alu_op and out_rd_addr to 0.
REQ-028 SHALL drop any in-flight instruction on reset asserted mid-operation; no write occurs that cycle.

Configuration
REQ-029 SHALL use macro OPFETCH_BYPASS_EN: when defined, a same-cycle writeback to a source register clears that hazard and forwards wb_data to the operand (issue in the writeback cycle).
REQ-030 SHALL, without OPFETCH_BYPASS_EN, have no forwarding; the instruction issues the cycle after writeback and reads the register file.

Structure
REQ-031 SHALL take XLEN default, reg_addr_t (5-bit) and the alu_op_t encoding from shared package rv_pkg: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
REQ-032 SHALL put the register file in sub-module regfile_2r1w (two async reads, one sync write, x0 zero).

Verification
REQ-033 SHALL cover: reset; wb x5=0x1234; issue ADD rs1=x5 rs2=x0 -> out_rs1=0x1234, out_rs2=0, out_valid one cycle after accept.
REQ-034 SHALL cover: issue rd=x3; next instruction rs1=x3 -> in_ready=0 until wb x3=0x00AA; with bypass it issues in the wb cycle with out_rs1=0x00AA; without bypass it issues one cycle later.
REQ-035 SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged and in_ready=0; out_ready=1 -> the next accept proceeds.
REQ-036 SHALL cover: in_use_imm=1, in_imm=0xFFF0, rs2=x7 busy -> no stall, out_rs2=0xFFF0.
REQ-037 SHALL cover: wb x0=0xBEEF, then read x0 -> 0; flush with x4 busy -> busy cleared, out_valid=0 next cycle.
REQ-038 SHALL cover: same-cycle issue of rd=x6 and wb x6 -> busy[6] remains 1.
